// File: rtl/digit_uart_tx.sv
// Classifier result reporter: each accepted digit is sent as an ASCII frame
// (digit char, CR, LF) over an 8N1, LSB-first UART line.
module digit_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [7:0] digit,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   baud_cnt, baud_nx;
    logic [2:0]      bit_idx, bit_nx;
    logic [1:0]      byte_idx, byte_nx;
    logic [7:0]      char_q, char_nx;
    logic [7:0]      cur_byte;
    logic            tx_d;
    logic            baud_done;

    assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    // State register; tx is registered so the pin never sees decode glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            char_q   <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_idx  <= bit_nx;
            byte_idx <= byte_nx;
            char_q   <= char_nx;
            tx       <= tx_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_idx;
        byte_nx  = byte_idx;
        char_nx  = char_q;
        case (state)
            S_IDLE: begin
                if (digit_valid) begin
                    state_nx = S_START;
                    baud_nx  = '0;
                    byte_nx  = 2'd0;
                    char_nx  = (digit <= 8'd9) ? (8'h30 + digit) : 8'h3F;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_nx  = '0;
                    bit_nx   = 3'd0;
                    state_nx = S_DATA;
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) state_nx = S_STOP;
                    else                 bit_nx   = bit_idx + 3'd1;
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_nx = '0;
                    if (byte_idx < 2'd2) begin
                        byte_nx  = byte_idx + 2'd1;
                        state_nx = S_START;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs; tx_d looks one cycle ahead so the register lands on the right bit
    always_comb begin
        ready = (state == S_IDLE);
        busy  = ~ready;
        case (byte_idx)
            2'd0:    cur_byte = char_q;
            2'd1:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
        case (state_nx)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_nx];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_digit_uart_tx.sv
// Directed bench for digit_uart_tx at CLKS_PER_BIT=4 (40 cycles per byte).
module tb_digit_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digit_valid;
    logic [7:0] digit;
    logic       ready, busy, tx;

    int errors = 0;
    int checks = 0;

    logic txs [0:299];
    logic bsy [0:299];

    digit_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_valid (digit_valid),
        .digit       (digit),
        .ready       (ready),
        .busy        (busy),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    // Rebuild one 8N1 byte from per-cycle samples; bit 8 flags clean framing
    function automatic logic [8:0] decode(int base);
        logic [7:0] d;
        logic       ok;
        ok = 1'b1;
        d  = '0;
        for (int s = 0; s < 10; s++) begin
            logic v;
            v = txs[base + s*CPB];
            for (int k = 1; k < CPB; k++)
                if (txs[base + s*CPB + k] !== v) ok = 1'b0;
            if (s == 0 && v !== 1'b0) ok = 1'b0;
            if (s == 9 && v !== 1'b1) ok = 1'b0;
            if (s >= 1 && s <= 8) d[s-1] = v;
        end
        return {ok, d};
    endfunction

    // Accept d on the next edge, then record n cycles; cycle 0 follows the accept edge.
    // A pulse of pulse_digit is injected on the edge after cycle pulse_at.
    task automatic run_frame(input logic [7:0] d, input int n, input int pulse_at,
                             input logic [7:0] pulse_digit);
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = d;
        @(posedge clk);
        #1 digit_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            txs[i] = tx;
            bsy[i] = busy;
            digit_valid = (i == pulse_at);
            if (i == pulse_at) digit = pulse_digit;
        end
        digit_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        digit_valid = 1'b0;
        digit       = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, ready, busy} !== 3'b110) begin
                errors++;
                $display("FAIL reset cyc%0d: tx/ready/busy=%b want 110", i, {tx, ready, busy});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx, ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release: tx/ready/busy=%b want 110", {tx, ready, busy});
        end
    endtask

    task automatic test_digit7;
        logic [7:0] exp [3] = '{8'h37, 8'h0D, 8'h0A};
        logic [8:0] r;
        int         nb;
        run_frame(8'd7, 121, -1, 8'd0);
        for (int b = 0; b < 3; b++) begin
            r = decode(b*40);
            checks++;
            if (r !== {1'b1, exp[b]}) begin
                errors++;
                $display("FAIL digit7 byte%0d: ok=%b data=%h want ok=1 data=%h", b, r[8], r[7:0], exp[b]);
            end
        end
        nb = 0;
        for (int i = 0; i < 121; i++) nb += int'(bsy[i]);
        checks++;
        if (nb != 120 || bsy[119] !== 1'b1 || bsy[120] !== 1'b0 || txs[120] !== 1'b1) begin
            errors++;
            $display("FAIL digit7_busy: busy_cycles=%0d end_busy=%b want 120 and 0", nb, bsy[120]);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL digit7_ready: ready=%b want 1", ready);
        end
    endtask

    task automatic test_mapping;
        logic [7:0] d_in [2] = '{8'd12, 8'd0};
        logic [7:0] first[2] = '{8'h3F, 8'h30};
        logic [8:0] r;
        for (int t = 0; t < 2; t++) begin
            run_frame(d_in[t], 121, -1, 8'd0);
            r = decode(0);
            checks++;
            if (r !== {1'b1, first[t]}) begin
                errors++;
                $display("FAIL map_d%0d byte0: ok=%b data=%h want ok=1 data=%h", d_in[t], r[8], r[7:0], first[t]);
            end
            r = decode(80);
            checks++;
            if (r !== {1'b1, 8'h0A}) begin
                errors++;
                $display("FAIL map_d%0d byte2: ok=%b data=%h want ok=1 data=0a", d_in[t], r[8], r[7:0]);
            end
        end
    endtask

    task automatic test_ignore_busy;
        logic [7:0] exp [3] = '{8'h33, 8'h0D, 8'h0A};
        logic [8:0] r;
        run_frame(8'd3, 121, 20, 8'd5);
        for (int b = 0; b < 3; b++) begin
            r = decode(b*40);
            checks++;
            if (r !== {1'b1, exp[b]}) begin
                errors++;
                $display("FAIL ignore byte%0d: ok=%b data=%h want ok=1 data=%h", b, r[8], r[7:0], exp[b]);
            end
        end
        checks++;
        if (bsy[119] !== 1'b1 || bsy[120] !== 1'b0 || txs[120] !== 1'b1) begin
            errors++;
            $display("FAIL ignore_ready: busy@119=%b busy@120=%b tx@120=%b want 1 0 1", bsy[119], bsy[120], txs[120]);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [6] = '{8'h31, 8'h0D, 8'h0A, 8'h32, 8'h0D, 8'h0A};
        logic [8:0] r;
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = 8'd1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 242; i++) begin
            @(negedge clk);
            txs[i] = tx;
            bsy[i] = busy;
            if (i == 120) digit = 8'd2;
            if (i == 121) digit_valid = 1'b0;
        end
        // One ready cycle at 120, second frame starts on cycle 121
        for (int b = 0; b < 6; b++) begin
            r = decode((b < 3) ? b*40 : 121 + (b-3)*40);
            checks++;
            if (r !== {1'b1, exp[b]}) begin
                errors++;
                $display("FAIL b2b byte%0d: ok=%b data=%h want ok=1 data=%h", b, r[8], r[7:0], exp[b]);
            end
        end
        checks++;
        if (bsy[120] !== 1'b0 || bsy[121] !== 1'b1 || bsy[240] !== 1'b1 || bsy[241] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: busy@120/121/240/241=%b%b%b%b want 0110", bsy[120], bsy[121], bsy[240], bsy[241]);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp [3] = '{8'h39, 8'h0D, 8'h0A};
        logic [8:0] r;
        run_frame(8'd4, 51, -1, 8'd0);
        // Cycle 50 is CR data bit 1, which is 0
        checks++;
        if (txs[50] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: tx@50=%b want 0", txs[50]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL midrst_async: tx/ready/busy=%b want 110", {tx, ready, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx, ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL midrst_release: tx/ready/busy=%b want 110", {tx, ready, busy});
        end
        run_frame(8'd9, 121, -1, 8'd0);
        for (int b = 0; b < 3; b++) begin
            r = decode(b*40);
            checks++;
            if (r !== {1'b1, exp[b]}) begin
                errors++;
                $display("FAIL midrst_d9 byte%0d: ok=%b data=%h want ok=1 data=%h", b, r[8], r[7:0], exp[b]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_digit7;
        test_mapping;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
